// File: rtl/powerup_spawner_if.sv
// +----------------------------------------------------------------------+
// | powerup_spawner_if: power-up spawner <-> game logic signal bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface powerup_spawner_if;
    logic       enable;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] pp_status;
    logic [9:0] pp_x;
    logic [9:0] pp_y;
    logic       pp_visible;
    logic       eaten;
    logic [1:0] mode;

    // master is the spawner itself; slave is the surrounding game logic
    modport master (
        input  enable, ball_x, ball_y, pp_status,
        output pp_x, pp_y, pp_visible, eaten, mode
    );

    modport slave (
        output enable, ball_x, ball_y, pp_status,
        input  pp_x, pp_y, pp_visible, eaten, mode
    );
endinterface

`default_nettype wire

// File: rtl/powerup_spawner.sv
// +----------------------------------------------------------------------+
// | powerup_spawner: places a power-up box after a respawn delay and     |
// | reports ball collection with the collected type.   Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module powerup_spawner #(
    parameter int PRESCALER    = 64999999,
    parameter int RESPAWN_SEC  = 3,
    parameter int LIFETIME_SEC = 5,
    parameter int X_MIN        = 64,
    parameter int Y_MIN        = 112,
    parameter int PP_SIZE      = 16,
    parameter int BALL_SIZE    = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    powerup_spawner_if.master  pp
);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_PLACE   = 2'd1,
        S_SHOW    = 2'd2,
        S_COLLECT = 2'd3
    } state_t;

    localparam logic [25:0] c_PRESC    = 26'(PRESCALER);
    localparam logic [3:0]  c_RESPAWN  = (RESPAWN_SEC  == 0) ? 4'd1 : 4'(RESPAWN_SEC);
    localparam logic [3:0]  c_LIFETIME = (LIFETIME_SEC == 0) ? 4'd1 : 4'(LIFETIME_SEC);
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_MASK = 16'hB400;

    state_t      r_state;
    logic [25:0] r_presc;
    logic [3:0]  r_sec;
    logic [15:0] r_lfsr;
    logic [9:0]  r_pp_x;
    logic [9:0]  r_pp_y;
    logic        r_visible;
    logic        r_eaten;
    logic [1:0]  r_mode;
    logic [1:0]  r_pending;

    state_t      w_next;
    logic        w_tick;
    logic        w_last_sec;
    logic        w_load;
    logic        w_overlap;
    logic        w_free;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    logic [15:0] w_lfsr_next;
    logic [9:0]  w_x_cand;
    logic [9:0]  w_y_cand;
    logic [10:0] w_pp_x_end;
    logic [10:0] w_pp_y_end;
    logic [10:0] w_ball_x_end;
    logic [10:0] w_ball_y_end;

    assign w_tick      = (r_presc == c_PRESC);
    assign w_last_sec  = w_tick && (r_sec == 4'd1);
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);

    assign w_x_cand = 10'(X_MIN) + {1'b0, r_lfsr[8:0]};
    assign w_y_cand = 10'(Y_MIN) + {2'b00, r_lfsr[15:8]};

    // 11-bit box edges so a box near the right/bottom border cannot wrap
    assign w_pp_x_end   = {1'b0, r_pp_x}    + 11'(PP_SIZE);
    assign w_pp_y_end   = {1'b0, r_pp_y}    + 11'(PP_SIZE);
    assign w_ball_x_end = {1'b0, pp.ball_x} + 11'(BALL_SIZE);
    assign w_ball_y_end = {1'b0, pp.ball_y} + 11'(BALL_SIZE);

    assign w_overlap = ({1'b0, pp.ball_x} < w_pp_x_end)   &&
                       ({1'b0, r_pp_x}    < w_ball_x_end) &&
                       ({1'b0, pp.ball_y} < w_pp_y_end)   &&
                       ({1'b0, r_pp_y}    < w_ball_y_end);

    // first type not already running, scanning upward from the random candidate
    always_comb begin
        w_free = 1'b0;
        w_sel  = 2'b00;
        w_idx  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_lfsr[1:0] + 2'(i);
            if (!w_free && !pp.pp_status[w_idx]) begin
                w_free = 1'b1;
                w_sel  = w_idx;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (!pp.enable) begin
            w_next = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT:    if (w_last_sec) w_next = S_PLACE;
                S_PLACE:   if (w_free)     w_next = S_SHOW;
                S_SHOW: begin
                    if (w_overlap)       w_next = S_COLLECT;
                    else if (w_last_sec) w_next = S_WAIT;
                end
                S_COLLECT: w_next = S_WAIT;
                default:   w_next = S_WAIT;
            endcase
        end
    end

    // holding enable low keeps reloading the timer, so re-enable sees the full delay
    assign w_load = (w_next != r_state) || !pp.enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_WAIT;
            r_presc   <= 26'd0;
            r_sec     <= c_RESPAWN;
            r_lfsr    <= c_LFSR_SEED;
            r_pp_x    <= 10'd0;
            r_pp_y    <= 10'd0;
            r_visible <= 1'b0;
            r_eaten   <= 1'b0;
            r_mode    <= 2'b00;
            r_pending <= 2'b00;
        end else begin
            r_state <= w_next;
            r_lfsr  <= w_lfsr_next;

            if (w_load) begin
                r_presc <= 26'd0;
                r_sec   <= (w_next == S_SHOW) ? c_LIFETIME : c_RESPAWN;
            end else begin
                r_presc <= w_tick ? 26'd0 : r_presc + 26'd1;
                if (w_tick) begin
                    r_sec <= r_sec - 4'd1;
                end
            end

            if (r_state == S_PLACE && w_next == S_SHOW) begin
                r_pp_x    <= w_x_cand;
                r_pp_y    <= w_y_cand;
                r_pending <= w_sel;
            end

            r_visible <= (w_next == S_SHOW);
            r_eaten   <= (w_next == S_COLLECT);
            if (w_next == S_COLLECT) begin
                r_mode <= r_pending;
            end
        end
    end

    assign pp.pp_x       = r_pp_x;
    assign pp.pp_y       = r_pp_y;
    assign pp.pp_visible = r_visible;
    assign pp.eaten      = r_eaten;
    assign pp.mode       = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_powerup_spawner.sv
// +----------------------------------------------------------------------+
// | tb_powerup_spawner: vectors, corner sequences and random rounds      |
// | against a spec-level reference model.   Rev 1.0                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_powerup_spawner;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    powerup_spawner_if ifc();

    powerup_spawner #(
        .PRESCALER   (9),
        .RESPAWN_SEC (2),
        .LIFETIME_SEC(3),
        .X_MIN       (64),
        .Y_MIN       (112),
        .PP_SIZE     (16),
        .BALL_SIZE   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pp   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev is the value the design saw in the cycle before the last edge
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    function automatic logic [15:0] lfsr_step(logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    function automatic logic [1:0] ref_mode(logic [15:0] l, logic [3:0] st);
        int c;
        c = int'(l[1:0]);
        for (int k = 0; k < 4; k++) begin
            if (!st[(c + k) % 4]) return 2'((c + k) % 4);
        end
        return 2'b00;
    endfunction

    typedef struct {
        logic [3:0] status;
        logic [1:0] mode;
    } vec_t;

    vec_t        tbl [4];
    logic [1:0]  exp_pending;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ball_far();
        ifc.ball_x = 10'd0;
        ifc.ball_y = 10'd0;
    endtask

    task automatic ball_on_box();
        ifc.ball_x = ifc.pp_x;
        ifc.ball_y = ifc.pp_y;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges until the box shows up; checks delay, position and predicts the mode
    task automatic expect_spawn(input string name, input int exp_edges);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ifc.pp_visible && n < 200);
        check({name, "_delay"}, n, exp_edges);
        check({name, "_x"}, int'(ifc.pp_x), 64 + int'(m_prev[8:0]));
        check({name, "_y"}, int'(ifc.pp_y), 112 + int'(m_prev[15:8]));
        exp_pending = ref_mode(m_prev, ifc.pp_status);
    endtask

    // Ball onto the box, then expect exactly one eaten cycle with the given mode
    task automatic collect(input string name, input logic [1:0] exp_mode);
        ball_on_box();
        step();
        check({name, "_eaten"}, int'(ifc.eaten), 1);
        check({name, "_mode"}, int'(ifc.mode), int'(exp_mode));
        check({name, "_vis"}, int'(ifc.pp_visible), 0);
        ball_far();
        step();
        check({name, "_eaten_end"}, int'(ifc.eaten), 0);
    endtask

    task automatic expect_expire(input string name);
        int n;
        int seen;
        n    = 0;
        seen = 0;
        do begin
            step();
            n++;
            if (ifc.eaten) seen++;
        end while (ifc.pp_visible && n < 200);
        check({name, "_life"}, n, 30);
        check({name, "_no_eaten"}, seen, 0);
    endtask

    initial begin
        int          n;
        int          seen;
        int          d;
        logic [3:0]  st;
        logic [9:0]  bx;
        logic [9:0]  by;

        n_checks = 0;
        n_errors = 0;
        tbl[0] = '{status: 4'b1110, mode: 2'd0};
        tbl[1] = '{status: 4'b1101, mode: 2'd1};
        tbl[2] = '{status: 4'b1011, mode: 2'd2};
        tbl[3] = '{status: 4'b0111, mode: 2'd3};

        reset         = 1'b1;
        ifc.enable    = 1'b1;
        ifc.pp_status = 4'b0000;
        ball_far();
        repeat (2) @(negedge clk);
        check("rst_x",   int'(ifc.pp_x), 0);
        check("rst_y",   int'(ifc.pp_y), 0);
        check("rst_vis", int'(ifc.pp_visible), 0);
        check("rst_eat", int'(ifc.eaten), 0);
        check("rst_mode", int'(ifc.mode), 0);

        reset = 1'b0;
        expect_spawn("first", 21);
        expect_expire("expire");
        expect_spawn("after_expire", 21);
        collect("eat0", exp_pending);
        expect_spawn("after_eat", 21);

        // Single free type: mode is fixed regardless of the random candidate
        for (int i = 0; i < 4; i++) begin
            collect($sformatf("tbl%0d_prev", i), exp_pending);
            ifc.pp_status = tbl[i].status;
            expect_spawn($sformatf("tbl%0d", i), 21);
            check($sformatf("tbl%0d_pred", i), int'(exp_pending), int'(tbl[i].mode));
            ifc.pp_status = $urandom_range(0, 15);
            collect($sformatf("tbl%0d", i), tbl[i].mode);
            ifc.pp_status = 4'b0000;
            expect_spawn($sformatf("tbl%0d_re", i), 21);
        end

        // All types busy: stall in PLACE until bit 1 frees up
        collect("busy_prev", exp_pending);
        ifc.pp_status = 4'b1111;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifc.pp_visible) seen++;
        end
        check("busy_hidden", seen, 0);
        ifc.pp_status = 4'b1101;
        expect_spawn("busy_release", 1);
        collect("busy", 2'd1);
        ifc.pp_status = 4'b0000;

        // Overlap on the same cycle as the lifetime expiry tick
        expect_spawn("tickrace", 21);
        repeat (29) step();
        check("tickrace_vis", int'(ifc.pp_visible), 1);
        collect("tickrace", exp_pending);

        // Touching edges do not overlap; one pixel in does
        expect_spawn("edge", 21);
        bx = ifc.pp_x;
        by = ifc.pp_y;
        ifc.ball_x = bx + 10'd16; ifc.ball_y = by;
        step();
        check("edge_right", int'(ifc.eaten), 0);
        ifc.ball_x = bx - 10'd8;  ifc.ball_y = by;
        step();
        check("edge_left", int'(ifc.eaten), 0);
        ifc.ball_x = bx; ifc.ball_y = by + 10'd16;
        step();
        check("edge_bottom", int'(ifc.eaten), 0);
        check("edge_still_vis", int'(ifc.pp_visible), 1);
        ifc.ball_x = bx + 10'd15; ifc.ball_y = by + 10'd15;
        step();
        check("edge_corner_eat", int'(ifc.eaten), 1);
        check("edge_corner_mode", int'(ifc.mode), int'(exp_pending));
        ball_far();
        step();

        // Enable dropped during SHOW with the ball on the box
        expect_spawn("endrop", 21);
        ifc.enable = 1'b0;
        ball_on_box();
        step();
        check("endrop_vis", int'(ifc.pp_visible), 0);
        seen = int'(ifc.eaten);
        for (int i = 0; i < 5; i++) begin
            step();
            seen += int'(ifc.eaten) + int'(ifc.pp_visible);
        end
        check("endrop_quiet", seen, 0);
        ball_far();
        ifc.enable = 1'b1;
        expect_spawn("reenable", 21);

        // Async reset pulsed in the middle of WAIT
        collect("rst_prev", exp_pending);
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        check("arst_vis", int'(ifc.pp_visible), 0);
        check("arst_mode", int'(ifc.mode), 0);
        check("arst_x", int'(ifc.pp_x), 0);
        step();
        reset = 1'b0;
        expect_spawn("arst", 21);

        // Random rounds: either eaten after a random dwell or left to expire
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(0, 29);
                repeat (d) step();
                ifc.pp_status = $urandom_range(0, 15);
                collect($sformatf("rnd%0d_eat", r), exp_pending);
            end else begin
                expect_expire($sformatf("rnd%0d", r));
            end
            st = 4'($urandom_range(0, 14));
            ifc.pp_status = st;
            expect_spawn($sformatf("rnd%0d_spawn", r), 21);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
